sequenciador_instrucoes: RTL and testbench



---
 rtl/sequenciador_instrucoes_if.sv | 31 +++
 rtl/sequenciador_instrucoes.sv | 175 +++++++++++++++++
 tb/tb_sequenciador_instrucoes.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_instrucoes_if.sv
// Program-load, control and serial-output bundle between the sequencer and its host/downstream.
// Inputs carry the _i suffix and outputs the _o suffix, both seen from the sequencer side.
interface sequenciador_instrucoes_if #(
    parameter int INSTR_BITS = 4,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                    wr_en_i;
    logic [AW-1:0]           wr_addr_i;
    logic [INSTR_BITS+3:0]   wr_data_i;
    logic [AW:0]             prog_len_i;
    logic                    start_i;
    logic                    fim_i;
    logic                    instrucao_o;
    logic [3:0]              dados_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    erro_o;
    logic [AW-1:0]           pc_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, prog_len_i, start_i, fim_i,
        input  instrucao_o, dados_o, busy_o, done_o, erro_o, pc_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, prog_len_i, start_i, fim_i,
        output instrucao_o, dados_o, busy_o, done_o, erro_o, pc_o
    );
endinterface

// File: rtl/sequenciador_instrucoes.sv
// Program sequencer: shifts each stored instruction out MSB-first with its data word,
// then waits for a rising edge of fim (or a timeout) before moving to the next entry.
module sequenciador_instrucoes #(
    parameter int INSTR_BITS = 4,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    sequenciador_instrucoes_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = INSTR_BITS + 4;
    localparam int CW = $clog2(INSTR_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            mem [DEPTH];
    logic [INSTR_BITS-1:0]   sh_q, sh_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [AW:0]             len_q, len_d;
    logic [AW-1:0]           pc_q, pc_d;
    logic                    instr_q, instr_d;
    logic [3:0]              dados_q, dados_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    erro_q, erro_d;
    logic                    fim_q;

    logic                    fim_rise;
    logic                    last_entry;
    logic [AW:0]             len_sat;
    logic [W-1:0]            rd_entry;

    assign fim_rise   = bus.fim_i & ~fim_q;
    assign last_entry = ({1'b0, pc_q} == (len_q - LEN_ONE));
    assign len_sat    = (bus.prog_len_i > LEN_MAX) ? LEN_MAX : bus.prog_len_i;
    assign rd_entry   = mem[pc_q];

    // Program memory is only writable while the sequencer is not running.
    always_ff @(posedge clk) begin
        if (bus.wr_en_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            len_q   <= '0;
            pc_q    <= '0;
            instr_q <= 1'b0;
            dados_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            erro_q  <= 1'b0;
            fim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            dados_q <= dados_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            erro_q  <= erro_d;
            fim_q   <= bus.fim_i;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        len_d   = len_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        dados_d = dados_q;
        busy_d  = busy_q;
        done_d  = done_q;
        erro_d  = erro_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                instr_d = 1'b0;
                busy_d  = 1'b0;
                // Restart from DONE behaves exactly like a start from IDLE.
                if (bus.start_i) begin
                    pc_d   = '0;
                    done_d = 1'b0;
                    erro_d = 1'b0;
                    if (len_sat == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        len_d   = len_sat;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                sh_d    = rd_entry[W-1:4];
                dados_d = rd_entry[3:0];
                cnt_d   = CW'(INSTR_BITS);
                tmo_d   = '0;
                instr_d = 1'b0;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                instr_d = sh_q[INSTR_BITS-1];
                sh_d    = sh_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                instr_d = 1'b0;
                // A fim edge on the final timeout cycle still counts as completion.
                if (fim_rise) begin
                    if (last_entry) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_LOAD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    erro_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.instrucao_o = instr_q;
    assign bus.dados_o     = dados_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.erro_o      = erro_q;
    assign bus.pc_o        = pc_q;
endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Scoreboard bench: stimulus schedules per-cycle expectations, a negedge monitor compares them.
module tb_sequenciador_instrucoes;
    localparam int INSTR_BITS = 4;
    localparam int DEPTH      = 16;
    localparam int TIMEOUT    = 255;
    localparam int SCHED      = 8192;
    localparam int NEVER      = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sequenciador_instrucoes_if #(.INSTR_BITS(INSTR_BITS), .DEPTH(DEPTH)) bus ();

    sequenciador_instrucoes #(
        .INSTR_BITS(INSTR_BITS),
        .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          fim_sched [SCHED];
    logic [7:0]  img [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // fim value for edge N is scheduled in fim_sched[N].
    always @(posedge clk) begin
        #1;
        bus.fim_i = fim_sched[(cyc + 1) % SCHED];
    end

    function automatic string sname(int s);
        case (s)
            0: return "instrucao";
            1: return "dados";
            2: return "busy";
            3: return "done";
            4: return "erro";
            5: return "pc";
            default: return "unknown";
        endcase
    endfunction

    function automatic int actual(int s);
        case (s)
            0: return int'(bus.instrucao_o);
            1: return int'(bus.dados_o);
            2: return int'(bus.busy_o);
            3: return int'(bus.done_o);
            4: return int'(bus.erro_o);
            5: return int'(bus.pc_o);
            default: return -1;
        endcase
    endfunction

    function automatic void expect_at(int c, int s, int v, int cut);
        exp_t e;
        int   i;
        if (c >= cut) return;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d), required %0h",
                         sname(e.sig), e.cyc, cyc, e.val);
            end else if (actual(e.sig) != e.val) begin
                errors++;
                $display("FAIL %s @cycle %0d: got %0h, required %0h",
                         sname(e.sig), cyc, actual(e.sig), e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 600) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
            sb.delete();
        end
        step();
        step();
    endtask

    task automatic write_entry(int a, logic [7:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 4'(a);
        bus.wr_data_i = d;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic expect_all_zero(int c);
        for (int s = 0; s < 6; s++) expect_at(c, s, 0, NEVER);
    endtask

    // Start at edge t: entry k loads at edge E_k (E_0 = t), bits appear after E_k+2..E_k+5,
    // WAIT begins after E_k+5 and the fim rise at E_k+5+d advances to E_{k+1}.
    task automatic issue_run(input int len, input int d0, input int d1, input int d2,
                             input int h0, input int h1, input int h2,
                             input int cut, input bit tmo, output int t);
        int d[3];
        int h[3];
        int e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        h[0] = h0; h[1] = h1; h[2] = h2;
        t = cyc + 1;
        bus.prog_len_i = 5'(len);
        bus.start_i    = 1'b1;
        if (len == 0) begin
            expect_at(t, 3, 1, cut);
            expect_at(t, 4, 0, cut);
            for (int j = 0; j < 5; j++) begin
                expect_at(t + j, 2, 0, cut);
                expect_at(t + j, 0, 0, cut);
            end
        end else begin
            expect_at(t, 2, 1, cut);
            expect_at(t, 3, 0, cut);
            expect_at(t, 4, 0, cut);
            e = t;
            for (int k = 0; k < len; k++) begin
                expect_at(e, 5, k, cut);
                expect_at(e + 1, 1, int'(img[k][3:0]), cut);
                for (int i = 0; i < INSTR_BITS; i++)
                    expect_at(e + 2 + i, 0, int'(img[k][7-i]), cut);
                expect_at(e + 3, 2, 1, cut);
                expect_at(e + 6, 0, 0, cut);
                if (tmo) begin
                    expect_at(e + 259, 2, 1, cut);
                    expect_at(e + 259, 4, 0, cut);
                    expect_at(e + 260, 4, 1, cut);
                    expect_at(e + 260, 3, 1, cut);
                    expect_at(e + 260, 2, 0, cut);
                    expect_at(e + 260, 5, 0, cut);
                    expect_at(e + 260, 0, 0, cut);
                    break;
                end
                expect_at(e + 4 + d[k], 5, k, cut);
                for (int j = 0; j < h[k]; j++)
                    if (e + 5 + d[k] + j < cut) fim_sched[(e + 5 + d[k] + j) % SCHED] = 1'b1;
                e = e + 5 + d[k];
            end
            if (!tmo) begin
                expect_at(e, 3, 1, cut);
                expect_at(e, 2, 0, cut);
                expect_at(e, 4, 0, cut);
                expect_at(e, 5, len - 1, cut);
                expect_at(e, 0, 0, cut);
            end
        end
        step();
        bus.start_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cut;
        rst            = 1'b1;
        bus.wr_en_i    = 1'b0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.prog_len_i = '0;
        bus.start_i    = 1'b0;
        step();
        step();
        expect_all_zero(cyc);
        wait_drain();
        rst = 1'b0;
        step();

        img[0] = 8'b1011_0011;
        img[1] = 8'b0110_0101;
        img[2] = 8'b1111_1010;
        for (int k = 0; k < 3; k++) write_entry(k, img[k]);

        // Nominal three-entry program, fim pulsed two cycles into each WAIT.
        issue_run(3, 2, 2, 2, 1, 1, 1, NEVER, 1'b0, t);
        wait_drain();

        // Restart from DONE; fim held 10 cycles on entry 0 must advance exactly once.
        issue_run(3, 2, 6, 2, 10, 1, 1, NEVER, 1'b0, t);
        wait_drain();

        // fim never arrives: abort on timeout with pc frozen at entry 0.
        issue_run(2, 0, 0, 0, 0, 0, 0, NEVER, 1'b1, t);
        wait_drain();

        // Empty program: done immediately, busy never rises, erro cleared.
        issue_run(0, 0, 0, 0, 0, 0, 0, NEVER, 1'b0, t);
        wait_drain();

        // Write and start while shifting are ignored.
        issue_run(1, 2, 0, 0, 1, 0, 0, NEVER, 1'b0, t);
        step();
        step();
        bus.wr_en_i    = 1'b1;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = 8'hFF;
        bus.prog_len_i = 5'd3;
        bus.start_i    = 1'b1;
        step();
        bus.wr_en_i    = 1'b0;
        bus.start_i    = 1'b0;
        wait_drain();
        issue_run(1, 2, 0, 0, 1, 0, 0, NEVER, 1'b0, t);
        wait_drain();

        // Async reset in the middle of entry 1's shift, then replay from entry 0.
        cut = cyc + 11;
        issue_run(3, 2, 2, 2, 1, 1, 1, cut, 1'b0, t);
        while (cyc < cut) step();
        rst = 1'b1;
        expect_all_zero(cyc);
        for (int j = 0; j < 64; j++) fim_sched[(cyc + 1 + j) % SCHED] = 1'b0;
        step();
        expect_all_zero(cyc);
        step();
        rst = 1'b0;
        step();
        issue_run(1, 2, 0, 0, 1, 0, 0, NEVER, 1'b0, t);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
